imm_extend_pipe: RTL

//  Parametrised, registered successor to the combinational decode-stage sign extender.
//  - Classifies each LEGv8 instruction by format and produces a WORD-wide immediate.
//  - Covers: I-type zero-extend, IW MOVZ with hw shift, R-type shift amount, optional branch x4 scaling.
//  - One-entry output register with valid/ready handshake; sits between fetch/IF-ID and decode/ID-EX.

---
 rtl/imm_pkg.sv | 54 +++++
 rtl/imm_decode_comb.sv | 70 +++++++
 rtl/imm_extend_pipe.sv | 79 +++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared format codes and LEGv8 opcode constants for the immediate extender.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_D   = 3'd2,
        FMT_B   = 3'd3,
        FMT_CB  = 3'd4,
        FMT_IW  = 3'd5,
        FMT_ILL = 3'd6
    } imm_fmt_e;

    // D-format loads/stores, opcode in [31:21]
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    // CB-format, opcode in [31:24]
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    // B-format, opcode in [31:26]
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    // IW-format MOVZ, opcode in [31:23]
    localparam logic [8:0]  OP_MOVZ  = 9'b110100101;
    // I-format, opcode in [31:22]
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
    localparam logic [9:0]  OP_ADDIS = 10'b1011000100;
    localparam logic [9:0]  OP_SUBIS = 10'b1111000100;
    // R-format shifts carry a shamt field
    localparam logic [10:0] OP_LSL   = 11'b11010011011;
    localparam logic [10:0] OP_LSR   = 11'b11010011010;
    // R-format register ops with no immediate
    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ANDS  = 11'b11101010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;
    localparam logic [10:0] OP_EOR   = 11'b11001010000;
    localparam logic [10:0] OP_BR    = 11'b11010110000;
    localparam logic [10:0] OP_MUL   = 11'b10011011000;
    localparam logic [10:0] OP_DIV   = 11'b10011010110;

    // True for R-format opcodes whose immediate is simply zero
    function automatic logic is_r_plain(input logic [10:0] op);
        return (op == OP_ADD)  || (op == OP_ADDS) || (op == OP_SUB) ||
               (op == OP_SUBS) || (op == OP_AND)  || (op == OP_ANDS) ||
               (op == OP_ORR)  || (op == OP_EOR)  || (op == OP_BR) ||
               (op == OP_MUL)  || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational LEGv8 format classifier and immediate extender.
module imm_decode_comb
    import imm_pkg::*;
#(
    parameter int WORD     = 64,
    parameter bit BR_SCALE = 1'b0,
    parameter bit FLAG_ILL = 1'b1
) (
    input  logic [31:0]     i_instr,
    output logic [WORD-1:0] o_imm,
    output imm_fmt_e        o_fmt,
    output logic            o_illegal
);

    logic [WORD-1:0] w_sext_d;
    logic [WORD-1:0] w_sext_cb;
    logic [WORD-1:0] w_sext_b;
    logic [63:0]     w_movz;
    logic            w_unused;

    // Branch scaling is applied after sign extension so the sign survives the shift
    function automatic logic [WORD-1:0] br_scale(input logic [WORD-1:0] v);
        return BR_SCALE ? {v[WORD-3:0], 2'b00} : v;
    endfunction

    assign w_sext_d  = {{(WORD-9){i_instr[20]}},  i_instr[20:12]};
    assign w_sext_cb = {{(WORD-19){i_instr[23]}}, i_instr[23:5]};
    assign w_sext_b  = {{(WORD-26){i_instr[25]}}, i_instr[25:0]};
    // hw field selects a 16-bit lane; a 64-bit scratch holds every lane before truncation
    assign w_movz    = {48'd0, i_instr[20:5]} << {i_instr[22:21], 4'b0000};
    // Destination register field never contributes to an immediate
    assign w_unused  = ^i_instr[4:0];

    // First matching format wins; anything unmatched falls through as illegal
    always_comb begin
        o_imm     = '0;
        o_fmt     = FMT_ILL;
        o_illegal = FLAG_ILL;
        if (i_instr[31:21] == OP_LDUR || i_instr[31:21] == OP_STUR) begin
            o_imm     = w_sext_d;
            o_fmt     = FMT_D;
            o_illegal = 1'b0;
        end else if (i_instr[31:24] == OP_CBZ || i_instr[31:24] == OP_CBNZ) begin
            o_imm     = br_scale(w_sext_cb);
            o_fmt     = FMT_CB;
            o_illegal = 1'b0;
        end else if (i_instr[31:26] == OP_B || i_instr[31:26] == OP_BL) begin
            o_imm     = br_scale(w_sext_b);
            o_fmt     = FMT_B;
            o_illegal = 1'b0;
        end else if (i_instr[31:23] == OP_MOVZ) begin
            o_imm     = WORD'(w_movz);
            o_fmt     = FMT_IW;
            o_illegal = 1'b0;
        end else if (i_instr[31:22] == OP_ADDI  || i_instr[31:22] == OP_SUBI ||
                     i_instr[31:22] == OP_ADDIS || i_instr[31:22] == OP_SUBIS) begin
            o_imm     = {{(WORD-12){1'b0}}, i_instr[21:10]};
            o_fmt     = FMT_I;
            o_illegal = 1'b0;
        end else if (i_instr[31:21] == OP_LSL || i_instr[31:21] == OP_LSR) begin
            o_imm     = {{(WORD-6){1'b0}}, i_instr[15:10]};
            o_fmt     = FMT_R;
            o_illegal = 1'b0;
        end else if (is_r_plain(i_instr[31:21])) begin
            o_fmt     = FMT_R;
            o_illegal = 1'b0;
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender: one-entry output stage with valid/ready and flush.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int WORD      = 64,
    parameter int INSTR_LEN = 32,
    parameter bit BR_SCALE  = 1'b0,
    parameter bit FLAG_ILL  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_LEN-1:0] in_instr,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD-1:0]      out_imm,
    output logic [2:0]           out_fmt,
    output logic                 out_illegal
);

    logic            r_valid;
    logic [WORD-1:0] r_imm;
    imm_fmt_e        r_fmt;
    logic            r_illegal;

    logic [WORD-1:0] w_imm;
    imm_fmt_e        w_fmt;
    logic            w_illegal;
    logic            w_accept;

    imm_decode_comb #(
        .WORD     (WORD),
        .BR_SCALE (BR_SCALE),
        .FLAG_ILL (FLAG_ILL)
    ) u_decode (
        .i_instr   (in_instr),
        .o_imm     (w_imm),
        .o_fmt     (w_fmt),
        .o_illegal (w_illegal)
    );

    // Empty or draining stage can take a new instruction; flush squashes the accept
    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    // Valid bit: flush beats accept, accept beats drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Payload changes only on accept, so a stalled entry stays stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imm     <= '0;
            r_fmt     <= FMT_R;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_imm     <= w_imm;
            r_fmt     <= w_fmt;
            r_illegal <= w_illegal;
        end
    end

    assign out_valid   = r_valid;
    assign out_imm     = r_imm;
    assign out_fmt     = r_fmt;
    assign out_illegal = r_illegal;

endmodule
